signal_group_sampler: RTL and testbench

SIGNAL_GROUP_SAMPLER -- requirements
Module: signal_group_sampler

---
 rtl/signal_group_sampler.sv | 167 ++++++++++++++++
 tb/tb_signal_group_sampler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/signal_group_sampler.sv
// rtl/signal_group_sampler.sv - samples a signal group periodically or on change into a timestamped FWFT record FIFO
//
// Purpose:
//   Watches WIDTH channels. In periodic mode a record is taken every PERIOD
//   cycles while enabled; in on-change mode a record is taken in every cycle
//   where the group differs from its value one cycle earlier. Each record is
//   {timestamp, group} and is queued in a DEPTH-entry first-word-fall-through
//   FIFO. Records arriving while the FIFO is full and not draining are dropped
//   and counted.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   en         in   sampling enable
//   mode       in   0 = periodic, 1 = on-change
//   sig        in   [WIDTH]  monitored channels (bit WIDTH-1 is channel 0)
//   clr_ovf    in   clears overflow flag and drop counter
//   out_ready  in   consumer accepts the head record
//   out_valid  out  head record valid
//   out_data   out  [TS_W+WIDTH] head record {timestamp, group}, 0 when empty
//   count      out  [clog2(DEPTH)+1] records held
//   overflow   out  sticky: a record was dropped
//   drop_cnt   out  [8] dropped records, saturating at 255

module signal_group_sampler #(
  parameter int WIDTH  = 3,
  parameter int PERIOD = 15,
  parameter int DEPTH  = 8,
  parameter int TS_W   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          mode,
  input  logic [WIDTH-1:0]              sig,
  input  logic                          clr_ovf,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [TS_W+WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          overflow,
  output logic [7:0]                    drop_cnt
);

  localparam int REC_W = TS_W + WIDTH;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PH_W  = $clog2(PERIOD);

  // free-running timestamp and one-cycle-old copy of the group
  logic [TS_W-1:0]  r_ts;
  logic [WIDTH-1:0] r_sig_q;

  // periodic phase counter
  logic [PH_W-1:0]  r_phase;

  // record FIFO
  logic [REC_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // drop bookkeeping
  logic             r_overflow;
  logic [7:0]       r_drop_cnt;

  logic             w_periodic;
  logic             w_phase_end;
  logic             w_changed;
  logic             w_trig;
  logic             w_full;
  logic             w_pop;
  logic             w_push_ok;
  logic             w_drop;
  logic [REC_W-1:0] w_rec;

  assign w_periodic  = en && !mode;
  assign w_phase_end = (r_phase == PH_W'(PERIOD - 1));
  assign w_changed   = (sig != r_sig_q);

  assign w_trig = (w_periodic && w_phase_end) || (en && mode && w_changed);

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid && out_ready;

  // A pop in the same cycle frees the slot, so a full FIFO that is draining
  // still accepts the new record.
  assign w_push_ok = w_trig && (!w_full || w_pop);
  assign w_drop    = w_trig && w_full && !w_pop;

  assign w_rec = {r_ts, sig};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ts    <= '0;
      r_sig_q <= '0;
    end else begin
      r_ts    <= r_ts + TS_W'(1);
      r_sig_q <= sig;
    end
  end

  // Held at 0 whenever periodic sampling is not active, so re-enabling
  // always yields the first trigger PERIOD cycles later.
  always_ff @(posedge clk) begin
    if (rst || !w_periodic) begin
      r_phase <= '0;
    end else if (w_phase_end) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + PH_W'(1);
    end
  end

  // Storage is not reset; out_data is gated by out_valid instead.
  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) begin
      r_mem[r_wr_ptr] <= w_rec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A drop in the same cycle as clr_ovf wins: the clear is applied first and
  // the new drop is then counted, leaving overflow=1 and drop_cnt=1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clr_ovf) begin
        r_drop_cnt <= 8'd1;
      end else if (r_drop_cnt != 8'hFF) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  assign out_data = out_valid ? r_mem[r_rd_ptr] : '0;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_signal_group_sampler.sv
// tb/tb_signal_group_sampler.sv - randomized self-checking bench for signal_group_sampler
module tb_signal_group_sampler;

  localparam int TW = 16;
  localparam int W  = 3;
  localparam int D  = 8;
  localparam int RW = TW + W;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          mode;
  logic [W-1:0]  sig;
  logic          clr_ovf;
  logic          out_ready;

  logic          a_valid, b_valid;
  logic [RW-1:0] a_data, b_data;
  logic [3:0]    a_count, b_count;
  logic          a_ovf, b_ovf;
  logic [7:0]    a_drop, b_drop;

  logic [32:0]   a_obs, b_obs;
  assign a_obs = {a_valid, a_data, a_count, a_ovf, a_drop};
  assign b_obs = {b_valid, b_data, b_count, b_ovf, b_drop};

  int total = 0;
  int bad   = 0;

  // reference model: timestamp, previous group, length of the current
  // periodic run, and per-instance record lists kept as plain arrays
  int            m_ts;
  logic [W-1:0]  m_sigq;
  int            m_run;
  logic [RW-1:0] m_rec [2][D];
  int            m_n   [2];
  logic          m_ovf [2];
  int            m_drop[2];

  signal_group_sampler #(.WIDTH(W), .PERIOD(15), .DEPTH(D), .TS_W(TW)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sig(sig), .clr_ovf(clr_ovf),
    .out_ready(out_ready), .out_valid(a_valid), .out_data(a_data),
    .count(a_count), .overflow(a_ovf), .drop_cnt(a_drop)
  );

  signal_group_sampler #(.WIDTH(W), .PERIOD(2), .DEPTH(D), .TS_W(TW)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sig(sig), .clr_ovf(clr_ovf),
    .out_ready(out_ready), .out_valid(b_valid), .out_data(b_data),
    .count(b_count), .overflow(b_ovf), .drop_cnt(b_drop)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic e, input logic m,
                       input logic [W-1:0] s, input logic c, input logic rd);
    rst = r; en = e; mode = m; sig = s; clr_ovf = c; out_ready = rd;
  endtask

  function automatic logic [32:0] exp_vec(input int k);
    logic [RW-1:0] h;
    h = (m_n[k] > 0) ? m_rec[k][0] : '0;
    return {m_n[k] > 0, h, 4'(m_n[k]), m_ovf[k], 8'(m_drop[k])};
  endfunction

  // Advances the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit            per;
    bit            pop;
    bit            trig [2];
    int            period [2];
    logic [RW-1:0] rec;
    period[0] = 15;
    period[1] = 2;
    if (rst) begin
      m_ts = 0; m_sigq = '0; m_run = 0;
      for (int k = 0; k < 2; k++) begin
        m_n[k] = 0; m_ovf[k] = 1'b0; m_drop[k] = 0;
      end
      return;
    end
    per = en && !mode;
    rec = {TW'(m_ts), sig};
    for (int k = 0; k < 2; k++) begin
      if (per) trig[k] = ((m_run % period[k]) == period[k] - 1);
      else     trig[k] = en && mode && (sig != m_sigq);
      pop = (m_n[k] > 0) && out_ready;
      if (trig[k] && m_n[k] == D && !pop) begin
        m_ovf[k]  = 1'b1;
        m_drop[k] = clr_ovf ? 1 : ((m_drop[k] < 255) ? m_drop[k] + 1 : 255);
      end else begin
        if (clr_ovf) begin
          m_ovf[k] = 1'b0; m_drop[k] = 0;
        end
        if (pop) begin
          for (int i = 0; i < D - 1; i++) m_rec[k][i] = m_rec[k][i+1];
          m_n[k]--;
        end
        if (trig[k]) begin
          m_rec[k][m_n[k]] = rec;
          m_n[k]++;
        end
      end
    end
    m_sigq = sig;
    m_ts   = (m_ts + 1) % (1 << TW);
    m_run  = per ? m_run + 1 : 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1, W'($urandom), 1'b0, 1'b1);
    tick();
    tick();
    total++; if (a_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", a_count); end
    total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", a_valid); end
    total++; if (a_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", a_data); end
    total++; if (a_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", a_ovf); end
    total++; if (a_drop !== 8'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", a_drop); end
    total++; if (b_obs !== exp_vec(1)) begin bad++; $display("FAIL reset_vec_b got=%h exp=%h", b_obs, exp_vec(1)); end
  endtask

  task automatic test_periodic();
    drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b1, 1'b0, 3'b101, 1'b0, 1'b1);
    for (int c = 0; c < 50; c++) begin
      total++; if (a_obs !== exp_vec(0)) begin bad++; $display("FAIL periodic_vec_a t=%0t got=%h exp=%h", $time, a_obs, exp_vec(0)); end
      total++; if (b_obs !== exp_vec(1)) begin bad++; $display("FAIL periodic_vec_b t=%0t got=%h exp=%h", $time, b_obs, exp_vec(1)); end
      if (c == 15 || c == 30 || c == 45) begin
        total++;
        if (a_valid !== 1'b1 || a_data !== {TW'(c - 1), 3'b101}) begin
          bad++; $display("FAIL periodic_rec ts=%0d got=%b/%h exp=1/%h", c, a_valid, a_data, {TW'(c - 1), 3'b101});
        end
      end
      tick();
    end
  endtask

  task automatic test_on_change();
    drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    tick();
    for (int c = 0; c < 12; c++) begin
      drive(1'b0, 1'b1, 1'b1, (c >= 5) ? 3'b011 : 3'b000, 1'b0, 1'b0);
      total++; if (a_obs !== exp_vec(0)) begin bad++; $display("FAIL change_vec_a t=%0t got=%h exp=%h", $time, a_obs, exp_vec(0)); end
      tick();
    end
    total++; if (a_count !== 4'd1) begin bad++; $display("FAIL change_count got=%0d exp=1", a_count); end
    total++; if (a_data !== {16'd5, 3'b011}) begin bad++; $display("FAIL change_rec got=%h exp=%h", a_data, {16'd5, 3'b011}); end
    total++; if (b_obs !== exp_vec(1)) begin bad++; $display("FAIL change_vec_b got=%h exp=%h", b_obs, exp_vec(1)); end
  endtask

  task automatic test_overflow();
    logic [TW-1:0] hd;
    drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    tick();
    for (int c = 0; c < 40; c++) begin
      drive(1'b0, 1'b1, 1'b0, W'($urandom), 1'b0, 1'b0);
      total++; if (b_obs !== exp_vec(1)) begin bad++; $display("FAIL ovf_vec_b t=%0t got=%h exp=%h", $time, b_obs, exp_vec(1)); end
      tick();
    end
    hd = b_data[RW-1:W];
    total++; if (b_count !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d exp=8", b_count); end
    total++; if (b_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", b_ovf); end
    total++; if (b_drop !== 8'd12) begin bad++; $display("FAIL ovf_drop got=%0d exp=12", b_drop); end
    total++; if (hd !== 16'd1) begin bad++; $display("FAIL ovf_first_ts got=%0d exp=1", hd); end
    // ts=40: no trigger; ts=41: trigger with a pop while full
    drive(1'b0, 1'b1, 1'b0, W'($urandom), 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b0, W'($urandom), 1'b0, 1'b1);
    tick();
    total++; if (b_count !== 4'd8) begin bad++; $display("FAIL full_pop_count got=%0d exp=8", b_count); end
    total++; if (b_drop !== 8'd12) begin bad++; $display("FAIL full_pop_drop got=%0d exp=12", b_drop); end
    // ts=42: clear with no drop
    drive(1'b0, 1'b1, 1'b0, W'($urandom), 1'b1, 1'b0);
    tick();
    total++; if (b_ovf !== 1'b0 || b_drop !== 8'd0) begin bad++; $display("FAIL clr_ovf got=%b/%0d exp=0/0", b_ovf, b_drop); end
    // ts=43: clear collides with a drop
    drive(1'b0, 1'b1, 1'b0, W'($urandom), 1'b1, 1'b0);
    tick();
    total++; if (b_ovf !== 1'b1 || b_drop !== 8'd1) begin bad++; $display("FAIL clr_vs_drop got=%b/%0d exp=1/1", b_ovf, b_drop); end
    for (int c = 0; c < 600; c++) begin
      drive(1'b0, 1'b1, 1'b0, W'($urandom), 1'b0, 1'b0);
      total++; if (a_obs !== exp_vec(0)) begin bad++; $display("FAIL sat_vec_a t=%0t got=%h exp=%h", $time, a_obs, exp_vec(0)); end
      total++; if (b_obs !== exp_vec(1)) begin bad++; $display("FAIL sat_vec_b t=%0t got=%h exp=%h", $time, b_obs, exp_vec(1)); end
      tick();
    end
    total++; if (b_drop !== 8'd255) begin bad++; $display("FAIL drop_saturate got=%0d exp=255", b_drop); end
  endtask

  task automatic test_back_to_back();
    logic          pv_a, pv_b, prd;
    logic [RW-1:0] pd_a, pd_b;
    logic [TW-1:0] hd;
    int            next_ts;
    drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    tick();
    pv_a = 1'b0; pv_b = 1'b0; prd = 1'b1; pd_a = '0; pd_b = '0;
    next_ts = 14;
    for (int c = 0; c < 300; c++) begin
      drive(1'b0, 1'b1, 1'b0, W'($urandom), 1'b0, c[0]);
      total++; if (a_obs !== exp_vec(0)) begin bad++; $display("FAIL bp_vec_a t=%0t got=%h exp=%h", $time, a_obs, exp_vec(0)); end
      total++; if (b_obs !== exp_vec(1)) begin bad++; $display("FAIL bp_vec_b t=%0t got=%h exp=%h", $time, b_obs, exp_vec(1)); end
      if (pv_a && !prd) begin
        total++; if (a_data !== pd_a) begin bad++; $display("FAIL bp_stable_a got=%h exp=%h", a_data, pd_a); end
      end
      if (pv_b && !prd) begin
        total++; if (b_data !== pd_b) begin bad++; $display("FAIL bp_stable_b got=%h exp=%h", b_data, pd_b); end
      end
      if (a_valid && out_ready) begin
        hd = a_data[RW-1:W];
        total++; if (hd !== TW'(next_ts)) begin bad++; $display("FAIL bp_order got=%0d exp=%0d", hd, next_ts); end
        next_ts += 15;
      end
      pv_a = a_valid; pv_b = b_valid; prd = out_ready; pd_a = a_data; pd_b = b_data;
      tick();
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    tick();
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b1, 1'b1, W'(c + 1), 1'b0, 1'b0);
      tick();
    end
    total++; if (a_count !== 4'd5) begin bad++; $display("FAIL mid_count_pre got=%0d exp=5", a_count); end
    drive(1'b1, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0);
    tick();
    total++; if (a_count !== 4'd0 || a_valid !== 1'b0) begin bad++; $display("FAIL mid_reset got=%0d/%b exp=0/0", a_count, a_valid); end
    total++; if (b_count !== 4'd0 || b_data !== '0) begin bad++; $display("FAIL mid_reset_b got=%0d/%h exp=0/0", b_count, b_data); end
    drive(1'b0, 1'b1, 1'b1, 3'b110, 1'b0, 1'b0);
    tick();
    total++; if (a_valid !== 1'b1 || a_data !== {16'd0, 3'b110}) begin bad++; $display("FAIL first_after_reset got=%b/%h exp=1/%h", a_valid, a_data, {16'd0, 3'b110}); end
  endtask

  task automatic test_random();
    logic          r_en, r_mode, r_clr, r_rd, r_rst;
    logic [W-1:0]  r_sig;
    r_sig = '0; r_mode = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      r_rst = ($urandom_range(0, 99) == 0);
      r_en  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) r_mode = ~r_mode;
      if ($urandom_range(0, 2) == 0) r_sig = W'($urandom);
      r_clr = ($urandom_range(0, 19) == 0);
      r_rd  = ((c / 200) % 2 == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
      drive(r_rst, r_en, r_mode, r_sig, r_clr, r_rd);
      total++; if (a_obs !== exp_vec(0)) begin bad++; $display("FAIL rand_vec_a t=%0t got=%h exp=%h", $time, a_obs, exp_vec(0)); end
      total++; if (b_obs !== exp_vec(1)) begin bad++; $display("FAIL rand_vec_b t=%0t got=%h exp=%h", $time, b_obs, exp_vec(1)); end
      tick();
    end
  endtask

  initial begin
    m_ts = 0; m_sigq = '0; m_run = 0;
    for (int k = 0; k < 2; k++) begin
      m_n[k] = 0; m_ovf[k] = 1'b0; m_drop[k] = 0;
    end
    test_reset();
    test_periodic();
    test_on_change();
    test_overflow();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
